// File: rtl/sort_pkg.sv
// Shared definitions for the sorting network and its output serializer.
package sort_pkg;

    localparam int unsigned W          = 32;
    localparam int unsigned N_ELEM     = 13;
    localparam int unsigned MEDIAN_IDX = 6;

    typedef logic [W-1:0] data_t;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StStream = 1'b1;

endpackage

// File: rtl/sort_13_serializer.sv
// Latches a sorted 13-word frame and streams it out one word per handshake,
// reporting the median and flagging frames that are not non-decreasing.
module sort_13_serializer #(
    parameter int unsigned N_ELEM     = sort_pkg::N_ELEM,
    parameter int unsigned W          = sort_pkg::W,
    parameter int unsigned MEDIAN_IDX = sort_pkg::MEDIAN_IDX
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sort_0,
    input  logic [W-1:0] sort_1,
    input  logic [W-1:0] sort_2,
    input  logic [W-1:0] sort_3,
    input  logic [W-1:0] sort_4,
    input  logic [W-1:0] sort_5,
    input  logic [W-1:0] sort_6,
    input  logic [W-1:0] sort_7,
    input  logic [W-1:0] sort_8,
    input  logic [W-1:0] sort_9,
    input  logic [W-1:0] sort_10,
    input  logic [W-1:0] sort_11,
    input  logic [W-1:0] sort_12,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic [3:0]   out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [W-1:0] median,
    output logic         median_valid,
    output logic         order_err
);
    import sort_pkg::*;

    localparam logic [3:0] LastIdx = 4'(N_ELEM - 1);

    logic [W-1:0] frame_in [N_ELEM];
    logic [W-1:0] frame_q  [N_ELEM];
    logic [0:0]   state_q, state_d;
    logic [3:0]   idx_q, idx_d, prev_idx;
    logic         err_q, err_d;
    logic [W-1:0] median_q, median_d;
    logic         median_valid_q, median_valid_d;
    logic         order_err_q, order_err_d;
    logic         accept, out_hs, is_last, beat_err;

    assign frame_in[0]  = sort_0;
    assign frame_in[1]  = sort_1;
    assign frame_in[2]  = sort_2;
    assign frame_in[3]  = sort_3;
    assign frame_in[4]  = sort_4;
    assign frame_in[5]  = sort_5;
    assign frame_in[6]  = sort_6;
    assign frame_in[7]  = sort_7;
    assign frame_in[8]  = sort_8;
    assign frame_in[9]  = sort_9;
    assign frame_in[10] = sort_10;
    assign frame_in[11] = sort_11;
    assign frame_in[12] = sort_12;

    assign is_last  = (idx_q == LastIdx);
    assign out_hs   = (state_q == StStream) && out_ready;
    // Combinational path from out_ready lets a new frame land on the last beat.
    assign in_ready = (state_q == StIdle) || (is_last && out_hs);
    assign accept   = in_valid && in_ready;

    assign prev_idx = (idx_q == 4'd0) ? 4'd0 : idx_q - 4'd1;
    assign beat_err = (idx_q != 4'd0) && (frame_q[idx_q] < frame_q[prev_idx]);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        err_d          = err_q;
        median_d       = median_q;
        median_valid_d = accept;
        order_err_d    = out_hs && is_last && (err_q || beat_err);
        if (accept) begin
            state_d  = StStream;
            idx_d    = 4'd0;
            err_d    = 1'b0;
            median_d = frame_in[MEDIAN_IDX];
        end else if (out_hs) begin
            if (beat_err) begin
                err_d = 1'b1;
            end
            if (is_last) begin
                state_d = StIdle;
                idx_d   = 4'd0;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            idx_q          <= 4'd0;
            err_q          <= 1'b0;
            median_q       <= '0;
            median_valid_q <= 1'b0;
            order_err_q    <= 1'b0;
            for (int i = 0; i < int'(N_ELEM); i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            err_q          <= err_d;
            median_q       <= median_d;
            median_valid_q <= median_valid_d;
            order_err_q    <= order_err_d;
            if (accept) begin
                for (int i = 0; i < int'(N_ELEM); i++) begin
                    frame_q[i] <= frame_in[i];
                end
            end
        end
    end

    assign out_valid    = (state_q == StStream);
    assign out_data     = frame_q[idx_q];
    assign out_idx      = idx_q;
    assign out_last     = out_valid && is_last;
    assign median       = median_q;
    assign median_valid = median_valid_q;
    assign order_err    = order_err_q;

endmodule

// File: tb/tb_sort_13_serializer.sv
// Directed bench for sort_13_serializer with hand-computed expected words.
module tb_sort_13_serializer;

    logic        clk;
    logic        rst_n;
    logic [31:0] s [13];
    logic        in_valid, in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_valid, out_ready, out_last;
    logic [31:0] median;
    logic        median_valid, order_err;

    logic [31:0] frm [13];
    logic [3:0]  pat;
    int          n_cmp;
    int          n_bad;

    sort_13_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sort_0       (s[0]),
        .sort_1       (s[1]),
        .sort_2       (s[2]),
        .sort_3       (s[3]),
        .sort_4       (s[4]),
        .sort_5       (s[5]),
        .sort_6       (s[6]),
        .sort_7       (s[7]),
        .sort_8       (s[8]),
        .sort_9       (s[9]),
        .sort_10      (s[10]),
        .sort_11      (s[11]),
        .sort_12      (s[12]),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .median       (median),
        .median_valid (median_valid),
        .order_err    (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers frm, streams it out with optional 1,0,0,1 back-pressure, checks every beat.
    task automatic run_frame(input bit exp_err, input bit stall);
        int j;
        int cyc;
        for (int i = 0; i < 13; i++) s[i] = frm[i];
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            step();
            cyc++;
        end
        check("in_ready_before_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("median", median, frm[6]);
        j = 0;
        cyc = 0;
        while (j < 13 && cyc < 200) begin
            out_ready = stall ? pat[cyc % 4] : 1'b1;
            check("beat_valid", out_valid, 1);
            check("beat_data", out_data, frm[j]);
            check("beat_idx", out_idx, j);
            check("beat_last", out_last, (j == 12));
            check("beat_median_valid", median_valid, (cyc == 0));
            check("beat_order_err", order_err, 0);
            if (out_ready) j++;
            step();
            cyc++;
        end
        check("beats_done", j, 13);
        out_ready = 1'b1;
        check("idle_valid", out_valid, 0);
        check("order_err_pulse", order_err, exp_err);
        step();
        check("order_err_after", order_err, 0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        pat       = 4'b1001;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) s[i] = 32'hdead0000 + i;
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_median", median, 0);
        check("rst_median_valid", median_valid, 0);
        check("rst_order_err", order_err, 0);
        #2 rst_n = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_idx", out_idx, 0);

        // Ascending 0..12, no back-pressure
        for (int i = 0; i < 13; i++) frm[i] = i;
        run_frame(1'b0, 1'b0);

        // Word 5 below word 4
        for (int i = 0; i < 13; i++) frm[i] = i * 10;
        frm[4] = 100;
        frm[5] = 50;
        run_frame(1'b1, 1'b0);

        // Stalled stream
        for (int i = 0; i < 13; i++) frm[i] = 200 + i;
        run_frame(1'b0, 1'b1);

        // All ones: equal neighbours are not an ordering error
        for (int i = 0; i < 13; i++) frm[i] = 32'hFFFFFFFF;
        run_frame(1'b0, 1'b1);

        // Back-to-back frames with in_valid held high
        for (int i = 0; i < 13; i++) s[i] = i * 3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 13; i++) s[i] = 100 + i;
        for (int c = 1; c <= 26; c++) begin
            if (c == 14) in_valid = 1'b0;
            check("b2b_valid", out_valid, 1);
            check("b2b_data", out_data, (c <= 13) ? 3 * (c - 1) : 100 + (c - 14));
            if (c == 12) check("b2b_in_ready_early", in_ready, 0);
            if (c == 13) check("b2b_in_ready_last", in_ready, 1);
            if (c == 14) check("b2b_median", median, 106);
            step();
        end
        check("b2b_idle", out_valid, 0);

        // Reset mid-frame after an ordering error at word 2
        for (int i = 0; i < 13; i++) s[i] = i * 10;
        s[1] = 50;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("mid_idx", out_idx, 5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_median", median, 0);
        step();
        #2 rst_n = 1'b1;
        step();
        check("mid_rel_in_ready", in_ready, 1);
        check("mid_rel_order_err", order_err, 0);
        repeat (14) begin
            check("mid_quiet_valid", out_valid, 0);
            check("mid_quiet_order_err", order_err, 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sort_13_serializer.md
SORT_13_SERIALIZER -- requirements
Module: sort_13_serializer

Interface
REQ-001 The block SHALL expose parameter N_ELEM, default 13: number of words per frame.
REQ-002 The block SHALL expose parameter W, default 32: word width in bits.
REQ-003 The block SHALL expose parameter MEDIAN_IDX, default 6: frame index reported as median.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 sort_0 .. sort_12  input  W each  parallel frame from the sorting network; index 0 = smallest.
REQ-007 in_valid  input  1  frame on sort_* is valid.
REQ-008 in_ready  output  1  block can accept a frame this cycle.
REQ-009 out_data  output  W  current serial word.
REQ-010 out_idx  output  4  index (0..N_ELEM-1) of out_data within the frame.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_last  output  1  out_data is frame word N_ELEM-1; valid only with out_valid.
REQ-014 median  output  W  registered word MEDIAN_IDX of the last accepted frame.
REQ-015 median_valid  output  1  one-cycle pulse when median updates.
REQ-016 order_err  output  1  one-cycle pulse: the frame just completed was not non-decreasing.

Function
REQ-017 The FSM SHALL have two states, IDLE and STREAM.
REQ-018 A frame SHALL be accepted on a rising edge where in_valid and in_ready are both 1; all N_ELEM words SHALL be latched into an internal buffer and idx SHALL be set to 0.
REQ-019 in_ready SHALL equal (state==IDLE) or (state==STREAM and idx==N_ELEM-1 and out_ready); this combinational path from out_ready is intentional.
REQ-020 In IDLE, out_valid SHALL be 0; acceptance SHALL move the FSM to STREAM.
REQ-021 In STREAM, out_valid SHALL be 1, out_data SHALL equal buf[idx], out_idx SHALL equal idx, and out_last SHALL be (idx==N_ELEM-1).
REQ-022 out_data, out_idx and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 On an out handshake with idx<N_ELEM-1, idx SHALL increment by 1.
REQ-024 On the last-beat handshake without a new frame, the FSM SHALL return to IDLE; with a simultaneous accepted frame, it SHALL remain in STREAM, reload the buffer and restart idx at 0, giving zero bubble cycles between frames.
REQ-025 First word latency SHALL be 1 cycle: out_valid rises the cycle after acceptance.
REQ-026 median SHALL load sort_MEDIAN_IDX on acceptance; median_valid SHALL pulse 1 in the following cycle.
REQ-027 For each beat with idx>0, an unsigned compare buf[idx] < buf[idx-1] SHALL set a per-frame error flag; the flag SHALL clear on acceptance.
REQ-028 order_err SHALL pulse 1 in the cycle after the last-beat handshake if the flag (including the last beat) is set; otherwise it SHALL stay 0.
REQ-029 Equal adjacent words SHALL NOT raise order_err.
REQ-030 in_valid while in_ready=0 SHALL be ignored; the sort_* inputs SHALL NOT be sampled then.

Reset
REQ-031 While rst_n=0: state=IDLE, idx=0, buffer=0, median=0, error flag=0, out_valid=0, median_valid=0, order_err=0; in_ready SHALL be 1 after release.
REQ-032 Assertion of rst_n mid-frame SHALL abort the frame immediately; no out_last and no order_err SHALL be produced for it.

Structure
REQ-033 Shared package sort_pkg SHALL hold data_t (logic [W-1:0]) and constants N_ELEM=13 and MEDIAN_IDX=6, shared with the sorting-network modules.
REQ-034 The block SHALL be a single module with no sub-module; it connects directly to the combinational sorter's sort_* outputs.

Verification
REQ-035 Reset, then frame 0..12 with out_ready=1: out_data 0..12 on 13 consecutive cycles, out_last on word 12, median=6, median_valid one pulse, order_err=0.
REQ-036 Frame with word 4=100 and word 5=50, otherwise ascending: order_err pulses once after the last beat.
REQ-037 out_ready toggles 1,0,0,1 throughout: every word appears exactly once, held stable during stalls, and the sequence is intact.
REQ-038 in_valid held high with two back-to-back frames: the second frame's word 0 follows the first frame's word 12 with no gap.
REQ-039 rst_n=0 at idx=5: out_valid=0 immediately, no order_err, and in_ready=1 after release.
REQ-040 All 13 words=0xFFFFFFFF: no order_err, median=0xFFFFFFFF.
